// File: rtl/multicycle_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multicycle_decoder                                              |
// | Purpose  : Registered SISP opcode decoder with multi-cycle mul/div hold.   |
// |            Optional macro BRANCH_EN decodes opcode 1000 as a branch.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module multicycle_decoder #(
    parameter int OPW     = 4,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_valid,
    input  logic [OPW-1:0] opcode,
    input  logic           abort,
    output logic           instr_ready,
    output logic           ctrl_valid,
    output logic           busy,
    output logic           illegal_op,
    output logic [1:0]     aluControl,
    output logic           regWrite,
    output logic           memWrite,
    output logic           flagUpdate,
    output logic           aluSrc,
    output logic           immSrc,
    output logic           memToReg,
    output logic           ra2Src,
    output logic           PCSrc
);

    localparam int c_max_lat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_cw      = $clog2(c_max_lat + 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_exec = 2'd1;
    localparam logic [1:0] c_wb   = 2'd2;

    // Field vector: [9:8] alu, 7 regWrite, 6 aluSrc, 5 flagUpdate, 4 memToReg,
    // 3 immSrc, 2 memWrite, 1 ra2Src, 0 illegal
    localparam logic [9:0] c_fld_rst = 10'b00_0_0_0_1_0_0_0_0;

    logic [1:0]      r_state;
    logic [c_cw-1:0] r_cnt;
    logic [9:0]      r_fld;
    logic [9:0]      w_fld;
    logic            w_hi;
    logic            w_multi;
    logic [c_cw-1:0] w_cnt_init;
    logic            w_accept;
    logic            w_abort;

    generate
        if (OPW > 4) begin : g_wide_op
            assign w_hi = |opcode[OPW-1:4];
        end else begin : g_narrow_op
            assign w_hi = 1'b0;
        end
    endgenerate

`ifdef BRANCH_EN
    logic w_pcs;
    logic r_pcs;
`endif

    always_comb begin
        w_fld      = c_fld_rst | 10'b00_0_0_0_0_0_0_0_1;
        w_multi    = 1'b0;
        w_cnt_init = '0;
`ifdef BRANCH_EN
        w_pcs      = 1'b0;
`endif
        if (!w_hi) begin
            case (opcode[3:0])
                4'b0000: begin
                    w_fld      = 10'b01_1_0_1_1_0_0_0_0;
                    w_multi    = (MUL_LAT > 1);
                    w_cnt_init = c_cw'(MUL_LAT - 1);
                end
                4'b0001: begin
                    w_fld      = 10'b01_1_1_1_1_0_0_0_0;
                    w_multi    = (MUL_LAT > 1);
                    w_cnt_init = c_cw'(MUL_LAT - 1);
                end
                4'b0010: begin
                    w_fld      = 10'b10_1_0_1_1_0_0_0_0;
                    w_multi    = (DIV_LAT > 1);
                    w_cnt_init = c_cw'(DIV_LAT - 1);
                end
                4'b0011: begin
                    w_fld      = 10'b10_1_1_1_1_0_0_0_0;
                    w_multi    = (DIV_LAT > 1);
                    w_cnt_init = c_cw'(DIV_LAT - 1);
                end
                4'b0100: w_fld = 10'b00_1_0_1_1_0_0_0_0;
                4'b0101: w_fld = 10'b00_1_1_1_0_1_0_0_0;
                4'b0110: w_fld = 10'b00_0_1_1_0_1_1_1_0;
                4'b0111: w_fld = 10'b11_1_0_1_1_0_0_0_0;
                4'b1111: w_fld = 10'b00_1_1_1_1_0_0_0_0;
`ifdef BRANCH_EN
                4'b1000: begin
                    w_fld = 10'b00_0_1_0_1_1_0_0_0;
                    w_pcs = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign instr_ready = !rst && (r_state != c_exec);
    assign w_accept    = instr_valid && instr_ready;
    // abort is only meaningful while an instruction is in flight
    assign w_abort     = abort && (r_state != c_idle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_fld   <= c_fld_rst;
        end else if (w_abort) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_fld   <= c_fld_rst;
        end else if (w_accept) begin
            r_fld   <= w_fld;
            r_state <= w_multi ? c_exec : c_wb;
            r_cnt   <= w_multi ? w_cnt_init : '0;
        end else begin
            case (r_state)
                c_exec: begin
                    r_cnt <= r_cnt - c_cw'(1);
                    if (r_cnt == c_cw'(1)) begin
                        r_state <= c_wb;
                    end
                end
                c_wb: begin
                    r_state <= c_idle;
                    r_fld   <= c_fld_rst;
                end
                default: ;
            endcase
        end
    end

`ifdef BRANCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcs <= 1'b0;
        end else if (w_abort) begin
            r_pcs <= 1'b0;
        end else if (w_accept) begin
            r_pcs <= w_pcs;
        end else if (r_state == c_wb) begin
            r_pcs <= 1'b0;
        end
    end
    assign PCSrc = r_pcs;
`else
    assign PCSrc = 1'b0;
`endif

    // A same-cycle abort also suppresses the writeback pulse
    assign ctrl_valid = (r_state == c_wb) && !abort;
    assign busy       = (r_state == c_exec);
    assign aluControl = r_fld[9:8];
    assign regWrite   = ctrl_valid && r_fld[7];
    assign aluSrc     = r_fld[6];
    assign flagUpdate = ctrl_valid && r_fld[5];
    assign memToReg   = r_fld[4];
    assign immSrc     = r_fld[3];
    assign memWrite   = ctrl_valid && r_fld[2];
    assign ra2Src     = r_fld[1];
    assign illegal_op = ctrl_valid && r_fld[0];

endmodule
`default_nettype wire

// File: tb/tb_multicycle_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_multicycle_decoder                                           |
// | Purpose  : Directed + randomized bench against a cycle-indexed model.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_multicycle_decoder;

    localparam int OPW     = 6;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           instr_valid;
    logic [OPW-1:0] opcode;
    logic           abort;
    logic           instr_ready, ctrl_valid, busy, illegal_op;
    logic [1:0]     aluControl;
    logic           regWrite, memWrite, flagUpdate;
    logic           aluSrc, immSrc, memToReg, ra2Src, PCSrc;

    multicycle_decoder #(.OPW(OPW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
        .abort(abort), .instr_ready(instr_ready), .ctrl_valid(ctrl_valid),
        .busy(busy), .illegal_op(illegal_op), .aluControl(aluControl),
        .regWrite(regWrite), .memWrite(memWrite), .flagUpdate(flagUpdate),
        .aluSrc(aluSrc), .immSrc(immSrc), .memToReg(memToReg),
        .ra2Src(ra2Src), .PCSrc(PCSrc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] alu;
        logic rw, asrc, fu, m2r, imm, mw, ra2, pcs, ill;
        logic [7:0] lat;
    } dec_t;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   m_wb = 0;
    logic m_inflight = 1'b0;
    dec_t m_f;

    function automatic dec_t dflt();
        dec_t d;
        d = '0;
        d.m2r = 1'b1;
        d.lat = 8'd1;
        return d;
    endfunction

    // Decode table written straight from the instruction set description
    function automatic dec_t ref_dec(input logic [OPW-1:0] op);
        dec_t d;
        d = dflt();
        if (op > 15) begin
            d.ill = 1'b1;
            return d;
        end
        case (op)
            0:  begin d.alu = 2'b01; d.rw = 1; d.fu = 1; d.lat = 8'(MUL_LAT); end
            1:  begin d.alu = 2'b01; d.rw = 1; d.asrc = 1; d.fu = 1; d.lat = 8'(MUL_LAT); end
            2:  begin d.alu = 2'b10; d.rw = 1; d.fu = 1; d.lat = 8'(DIV_LAT); end
            3:  begin d.alu = 2'b10; d.rw = 1; d.asrc = 1; d.fu = 1; d.lat = 8'(DIV_LAT); end
            4:  begin d.rw = 1; d.fu = 1; end
            5:  begin d.rw = 1; d.asrc = 1; d.fu = 1; d.m2r = 0; d.imm = 1; end
            6:  begin d.asrc = 1; d.fu = 1; d.m2r = 0; d.imm = 1; d.mw = 1; d.ra2 = 1; end
            7:  begin d.alu = 2'b11; d.rw = 1; d.fu = 1; end
            15: begin d.rw = 1; d.asrc = 1; d.fu = 1; end
`ifdef BRANCH_EN
            8:  begin d.pcs = 1; d.asrc = 1; d.imm = 1; end
`endif
            default: d.ill = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic [15:0] obs();
        return {2'b00, instr_ready, ctrl_valid, busy, illegal_op, aluControl, regWrite,
                memWrite, flagUpdate, aluSrc, immSrc, memToReg, ra2Src, PCSrc};
    endfunction

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model
    task automatic step(input logic v, input logic [OPW-1:0] op, input logic ab);
        dec_t f;
        logic ex, wb, rdy, cv;
        @(negedge clk);
        instr_valid = v;
        opcode      = op;
        abort       = ab;
        #1;
        wb  = m_inflight && (cyc == m_wb);
        ex  = m_inflight && (cyc < m_wb);
        rdy = !ex;
        cv  = wb && !ab;
        f   = m_inflight ? m_f : dflt();
        chk("cycle", obs(), {2'b00, rdy, cv, ex, cv & f.ill, f.alu, cv & f.rw, cv & f.mw,
                             cv & f.fu, f.asrc, f.imm, f.m2r, f.ra2, f.pcs});
        if (ab && m_inflight) begin
            m_inflight = 1'b0;
        end else if (v && rdy) begin
            m_f        = ref_dec(op);
            m_inflight = 1'b1;
            m_wb       = cyc + int'(m_f.lat);
        end else if (wb) begin
            m_inflight = 1'b0;
        end
        cyc++;
    endtask

    logic [OPW-1:0] pool [12];

    initial begin
        rst = 1'b1; instr_valid = 1'b0; opcode = '0; abort = 1'b0;
        pool[0] = 6'd0;  pool[1] = 6'd1;  pool[2] = 6'd2;  pool[3] = 6'd3;
        pool[4] = 6'd4;  pool[5] = 6'd5;  pool[6] = 6'd6;  pool[7] = 6'd7;
        pool[8] = 6'd15; pool[9] = 6'd8;  pool[10] = 6'd10; pool[11] = 6'b010100;

        repeat (2) @(negedge clk);
        #1 chk("reset_vals", obs(), 16'h0004);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("reset_ready", {15'd0, instr_ready}, 16'd1);

        // Multiply timing
        step(1, 6'd1, 0);
        step(0, 6'd0, 0);
        chk("mul_busy", {14'd0, busy, instr_ready}, 16'b10);
        step(0, 6'd0, 0);
        chk("mul_busy2", {14'd0, busy, ctrl_valid}, 16'b10);
        step(0, 6'd0, 0);
        chk("mul_wb", {10'd0, ctrl_valid, aluControl, aluSrc, regWrite, busy}, 16'b1_01_1_1_0);

        // Back-to-back add, store, load
        step(1, 6'd4, 0);
        step(1, 6'd6, 0);
        chk("b2b_add", {14'd0, ctrl_valid, regWrite}, 16'b11);
        step(1, 6'd5, 0);
        chk("b2b_store", {12'd0, ctrl_valid, memWrite, ra2Src, regWrite}, 16'b1110);
        step(0, 6'd0, 0);
        chk("b2b_load", {13'd0, ctrl_valid, memToReg, immSrc}, 16'b101);

        // Illegal opcodes, including high-bit case
        step(1, 6'b001010, 0);
        step(0, 6'd0, 0);
        chk("illegal_1010", {11'd0, ctrl_valid, illegal_op, regWrite, memWrite, flagUpdate}, 16'b11000);
        step(1, 6'b010100, 0);
        step(0, 6'd0, 0);
        chk("illegal_hi", {14'd0, ctrl_valid, illegal_op}, 16'b11);

        // Branch opcode
        step(1, 6'b001000, 0);
        step(0, 6'd0, 0);
`ifdef BRANCH_EN
        chk("branch", {13'd0, ctrl_valid, PCSrc, illegal_op}, 16'b110);
`else
        chk("branch_off", {13'd0, ctrl_valid, PCSrc, illegal_op}, 16'b101);
`endif

        // Abort mid-divide with a competing accept
        step(1, 6'd3, 0);
        repeat (3) step(0, 6'd0, 0);
        step(1, 6'd4, 1);
        chk("abort_cv", {15'd0, ctrl_valid}, 16'd0);
        step(0, 6'd0, 0);
        chk("abort_idle", {13'd0, instr_ready, busy, ctrl_valid}, 16'b100);
        repeat (9) step(0, 6'd0, 0);

        // Reset mid-EXEC
        step(1, 6'd2, 0);
        step(0, 6'd0, 0);
        step(0, 6'd0, 0);
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        #1 chk("rst_mid_exec", obs(), 16'h0004);
        @(negedge clk);
        rst = 1'b0;
        m_inflight = 1'b0;
        cyc += 2;
        #1 chk("rst_release", obs(), 16'h2004);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [OPW-1:0] op;
            op = ($urandom_range(0, 7) == 0) ? OPW'($urandom) : pool[$urandom_range(0, 11)];
            step($urandom_range(0, 3) != 0, op, $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_decoder.md
Name: multicycle_decoder

Overview:
Registered, parametrised successor to the single-cycle opcode decoder for the SISP datapath. It accepts one instruction opcode per handshake and decodes it into datapath control fields. Multiply and divide are held for a configurable number of cycles; the write enables are released only in the final (writeback) cycle. It sits between the fetch stage and the ALU/register-file/memory controls.

Parameters:
OPW, 4, opcode width; must be ≥4; any opcode with a nonzero bit above bit 3 is illegal.
MUL_LAT, 3, cycles from accept to ctrl_valid for opcodes 0000/0001; must be ≥1.
DIV_LAT, 8, cycles from accept to ctrl_valid for opcodes 0010/0011; must be ≥1.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
instr_valid  in  1  opcode is presented.
opcode  in  OPW  instruction opcode.
abort  in  1  synchronous; discards the in-flight instruction.
instr_ready  out  1  decoder can accept; equals !rst && state!=EXEC.
ctrl_valid  out  1  writeback cycle; pulses high for exactly one cycle per retired instruction.
busy  out  1  high when state is EXEC.
illegal_op  out  1  one-cycle pulse, same cycle as ctrl_valid, for an undecodable opcode.
aluControl  out  2  00 add, 01 mul, 10 div, 11 sub.
regWrite, memWrite, flagUpdate  out  1 each  write enables; asserted only while ctrl_valid=1.
aluSrc, immSrc, memToReg, ra2Src, PCSrc  out  1 each  steering fields; held stable from accept+1 through the ctrl_valid cycle.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, all outputs 0 except memToReg=1.
- Accept occurs when instr_valid && instr_ready. Opcode is latched and decoded; registered outputs update at the next edge.
- Latency LAT: MUL_LAT for 0000/0001, DIV_LAT for 0010/0011, 1 for all others.
- FSM states: IDLE, EXEC, WB.
  - Accept in IDLE or WB: if LAT==1 go to WB; else go to EXEC with cnt=LAT-1.
  - EXEC: cnt decrements each cycle. When cnt==1, next state is WB.
  - WB: ctrl_valid=1. Next state is IDLE, or a new accept the same cycle (back-to-back). ctrl_valid for an accept at cycle T is at T+LAT.
- Counter width is clog2(max(MUL_LAT,DIV_LAT)+1).
- Decode table (alu, regWrite, aluSrc, flagUpdate, memToReg, immSrc, memWrite, ra2Src):
  - 0000 mul reg: 01,1,0,1,1,0,0,0
  - 0001 mul imm: 01,1,1,1,1,0,0,0
  - 0010 div reg: 10,1,0,1,1,0,0,0
  - 0011 div imm: 10,1,1,1,1,0,0,0
  - 0100 add reg: 00,1,0,1,1,0,0,0
  - 0101 load: 00,1,1,1,0,1,0,0
  - 0110 store: 00,0,1,1,0,1,1,1
  - 0111 sub reg: 11,1,0,1,1,0,0,0
  - 1111 add imm: 00,1,1,1,1,0,0,0
  - Other opcodes: illegal. Default fields (00,0,0,0,1,0,0,0), LAT=1, illegal_op=1 in WB.
- PCSrc=0 for every opcode except as defined under the optional feature.
- In EXEC, the steering fields hold the decoded values. regWrite, memWrite and flagUpdate are 0.
- abort:
  - In EXEC or WB: next state IDLE, no ctrl_valid, all write enables 0, outputs return to reset values.
  - abort takes priority over a same-cycle accept; the accept is ignored.
  - In IDLE: no effect.
- instr_valid while !instr_ready: ignored; the opcode is not latched. The source must hold it.
- An opcode change while in EXEC has no effect on the latched instruction.

Optional Feature:
BRANCH_EN.
- Defined: opcode 1000 is an unconditional branch. LAT=1. In WB: PCSrc=1, aluSrc=1, immSrc=1, aluControl=00, regWrite=memWrite=flagUpdate=0, illegal_op=0.
- Undefined: 1000 is illegal and PCSrc is constant 0.

Test Plan:
- Reset mid-EXEC: accept 0010 (DIV_LAT=8), assert rst at T+3 → outputs zero immediately, memToReg=1, instr_ready=0 while rst=1, then 1 in IDLE.
- Mul timing: accept 0001 at T → busy=1 at T+1..T+2, ctrl_valid=1 only at T+3 with aluControl=01, aluSrc=1, regWrite=1; instr_ready=0 at T+1..T+2.
- Back-to-back: 0100 at T, 0110 at T+1, 0101 at T+2 → ctrl_valid at T+1,T+2,T+3; the store cycle shows memWrite=1, ra2Src=1, regWrite=0; the load cycle shows memToReg=0, immSrc=1.
- Illegal: opcode 1010 → ctrl_valid=1 and illegal_op=1 one cycle later, all write enables 0. With OPW=6, opcode 010100 is also illegal.
- Abort: accept 0011, abort at T+4 with instr_valid=1 and opcode 0100 → no ctrl_valid for either instruction, state IDLE at T+5, ready=1.
- BRANCH_EN: opcode 1000 → with macro, PCSrc=1 for one cycle and illegal_op=0; without macro, illegal_op=1 and PCSrc=0.
